// File: rtl/conv_pkg.sv
// conv_pkg: shared widths, sweep length and FSM state type for the convolution dot-product engine.
package conv_pkg;
    localparam int NUM_ADDR = 16;
    localparam int PIX_W    = 8;
    localparam int W_W      = 8;
    localparam int ACC_W    = 18;
    localparam int AW       = 6;
    // unsigned pixel widened by one sign bit times a signed weight
    localparam int PROD_W   = PIX_W + W_W + 1;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
endpackage

// File: rtl/conv_dot_engine_if.sv
// conv_dot_engine_if: valid/ready result stream.
// master drives valid, data (signed ACC_W), idx (4 bits) and receives ready; slave is the consumer.
interface conv_dot_engine_if;
    import conv_pkg::*;
    logic                    valid;
    logic                    ready;
    logic signed [ACC_W-1:0] data;
    logic [3:0]              idx;
    modport master(output valid, data, idx, input ready);
    modport slave(input valid, data, idx, output ready);
endinterface

// File: rtl/conv_dot4.sv
// conv_dot4: combinational 4-way unsigned-pixel x signed-weight multiply and 4-input adder tree.
// Ports: pix_i (4 pixels), w_i (4 weights) -> prod_o (4 products);
//        prod_i (4 registered products) -> sum_o (signed ACC_W sum).
module conv_dot4 import conv_pkg::*; (
    input  logic [4*PIX_W-1:0]      pix_i,
    input  logic [4*W_W-1:0]        w_i,
    output logic [4*PROD_W-1:0]     prod_o,
    input  logic [4*PROD_W-1:0]     prod_i,
    output logic signed [ACC_W-1:0] sum_o
);
    logic signed [ACC_W-1:0] e [4];
    for (genvar g = 0; g < 4; g++) begin : g_lane
        assign prod_o[g*PROD_W +: PROD_W] = PROD_W'($signed({1'b0, pix_i[g*PIX_W +: PIX_W]}))
                                          * PROD_W'($signed(w_i[g*W_W +: W_W]));
        assign e[g] = ACC_W'($signed(prod_i[g*PROD_W +: PROD_W]));
    end
    assign sum_o = (e[0] + e[1]) + (e[2] + e[3]);
endmodule

// File: rtl/conv_dot_engine.sv
// conv_dot_engine: sweeps buffer addresses 0..NUM_ADDR-1 and streams kernel dot products through a 2-stage pipeline.
// Ports: clk, rst (async, active-high); start_i, w_load_i, w_data_i (kernel, byte i = w[i]);
//        rd_addr_o / pix_in_i (combinational buffer read); busy_o, done_o; res_o (valid/ready result stream).
// Build option CONV_RELU_EN: when defined, negative sums are emitted as 0.
module conv_dot_engine import conv_pkg::*; (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic                  w_load_i,
    input  logic [4*W_W-1:0]      w_data_i,
    output logic [AW-1:0]         rd_addr_o,
    input  logic [4*PIX_W-1:0]    pix_in_i,
    output logic                  busy_o,
    output logic                  done_o,
    conv_dot_engine_if.master     res_o
);
    state_t                  state_q, state_d;
    logic [AW-1:0]           addr_q, addr_d;
    logic [4*W_W-1:0]        w_q, w_d;
    logic                    s1_v_q, s1_v_d;
    logic [4*PROD_W-1:0]     s1_p_q, s1_p_d, prod;
    logic [3:0]              s1_idx_q, s1_idx_d;
    logic                    v_q, v_d;
    logic signed [ACC_W-1:0] data_q, data_d, sum, res_val;
    logic [3:0]              idx_q, idx_d;
    logic                    stall, issue, last, idle;

    conv_dot4 u_dot4 (
        .pix_i  (pix_in_i),
        .w_i    (w_q),
        .prod_o (prod),
        .prod_i (s1_p_q),
        .sum_o  (sum)
    );

`ifdef CONV_RELU_EN
    assign res_val = sum[ACC_W-1] ? '0 : sum;
`else
    assign res_val = sum;
`endif

    always_comb begin
        idle     = state_q == IDLE;
        stall    = v_q && !res_o.ready;
        issue    = state_q == RUN && !stall;
        last     = addr_q == AW'(NUM_ADDR - 1);
        w_d      = idle && w_load_i ? w_data_i : w_q;
        addr_d   = issue ? (last ? '0 : addr_q + 1'b1) : (idle ? '0 : addr_q);
        s1_v_d   = stall ? s1_v_q : issue;
        s1_p_d   = stall ? s1_p_q : prod;
        s1_idx_d = stall ? s1_idx_q : addr_q[3:0];
        v_d      = stall ? v_q : s1_v_q;
        data_d   = stall ? data_q : res_val;
        idx_d    = stall ? idx_q : s1_idx_q;
        state_d  = state_q;
        case (state_q)
            IDLE:    state_d = start_i ? RUN : IDLE;
            RUN:     state_d = issue && last ? DRAIN : RUN;
            // finishing handshake with nothing left behind it in stage 1
            DRAIN:   state_d = v_q && res_o.ready && !s1_v_q ? DONE : DRAIN;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            w_q      <= '0;
            s1_v_q   <= 1'b0;
            s1_p_q   <= '0;
            s1_idx_q <= '0;
            v_q      <= 1'b0;
            data_q   <= '0;
            idx_q    <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            w_q      <= w_d;
            s1_v_q   <= s1_v_d;
            s1_p_q   <= s1_p_d;
            s1_idx_q <= s1_idx_d;
            v_q      <= v_d;
            data_q   <= data_d;
            idx_q    <= idx_d;
        end
    end

    assign rd_addr_o   = addr_q;
    assign busy_o      = state_q != IDLE;
    assign done_o      = state_q == DONE;
    assign res_o.valid = v_q;
    assign res_o.data  = data_q;
    assign res_o.idx   = idx_q;
endmodule

// File: tb/tb_conv_dot_engine.sv
// tb_conv_dot_engine: directed self-checking bench for conv_dot_engine.
module tb_conv_dot_engine;
    logic        clk = 1'b0;
    logic        rst;
    logic        start, w_load, mode;
    logic [31:0] w_data;
    logic [5:0]  rd_addr;
    logic [31:0] pix_in;
    logic        busy, done;
    int          errors = 0, checks = 0;
    int          cyc = 0, start_cyc = 0, done_cyc = 0, done_cnt = 0;
    int          q_data[$], q_idx[$], q_cyc[$];

    conv_dot_engine_if res();

    conv_dot_engine dut (
        .clk       (clk),
        .rst       (rst),
        .start_i   (start),
        .w_load_i  (w_load),
        .w_data_i  (w_data),
        .rd_addr_o (rd_addr),
        .pix_in_i  (pix_in),
        .busy_o    (busy),
        .done_o    (done),
        .res_o     (res)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // buffer model: every row slot returns rd_addr, or all pixels 255
    assign pix_in = mode ? 32'hFFFF_FFFF : {4{2'b00, rd_addr}};

    // inputs only change at posedge+1, so what is seen here is what the next edge takes
    always @(negedge clk) begin
        if (res.valid && res.ready) begin
            q_data.push_back(int'(res.data));
            q_idx.push_back(int'(res.idx));
            q_cyc.push_back(cyc);
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_w(input logic [31:0] w);
        tick();
        w_data = w;
        w_load = 1'b1;
        tick();
        w_load = 1'b0;
    endtask

    task automatic start_run(input logic ld, input logic [31:0] w);
        tick();
        q_data.delete();
        q_idx.delete();
        q_cyc.delete();
        done_cnt = 0;
        start = 1'b1;
        w_load = ld;
        w_data = w;
        tick();
        start = 1'b0;
        w_load = 1'b0;
        start_cyc = cyc;
    endtask

    task automatic wait_done();
        int n = 0;
        while (done_cnt == 0 && n < 300) begin
            tick();
            n++;
        end
        checks++;
        if (done_cnt == 0) begin
            errors++;
            $display("FAIL done_timeout: done=%0d required=1 within 300 cycles", done_cnt);
        end
        tick();
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        checks++;
        if ({rd_addr, busy, done, res.valid, res.idx} !== 13'd0 || res.data !== 18'sd0) begin
            errors++;
            $display("FAIL reset_outputs: addr=%0d busy=%0b done=%0b valid=%0b idx=%0d data=%0d required all 0",
                     rd_addr, busy, done, res.valid, res.idx, res.data);
        end
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_sweep();
        mode = 1'b0;
        res.ready = 1'b1;
        load_w(32'h0101_0101);
        start_run(1'b0, 32'h0);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL sweep_busy_high: busy=%0b required 1", busy);
        end
        wait_done();
        checks++;
        if (q_data.size() != 16) begin
            errors++;
            $display("FAIL sweep_count: got %0d results required 16", q_data.size());
        end
        for (int i = 0; i < q_data.size() && i < 16; i++) begin
            checks++;
            if (q_idx[i] != i || q_data[i] != 4 * i) begin
                errors++;
                $display("FAIL sweep_result[%0d]: idx=%0d data=%0d required idx=%0d data=%0d",
                         i, q_idx[i], q_data[i], i, 4 * i);
            end
        end
        checks++;
        if (q_cyc.size() != 16 || q_cyc[0] - start_cyc != 2 || q_cyc[15] - start_cyc != 17) begin
            errors++;
            $display("FAIL sweep_latency: first/last valid edges wrong (n=%0d) required +2/+17", q_cyc.size());
        end
        checks++;
        if (done_cnt != 1 || done_cyc - start_cyc != 18) begin
            errors++;
            $display("FAIL sweep_done: count=%0d offset=%0d required count=1 offset=18",
                     done_cnt, done_cyc - start_cyc);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL sweep_busy_low: busy=%0b required 0", busy);
        end
    endtask

    task automatic test_negative();
        int exp_v;
`ifdef CONV_RELU_EN
        exp_v = 0;
`else
        exp_v = -130560;
`endif
        mode = 1'b1;
        res.ready = 1'b1;
        load_w(32'h8080_8080);
        start_run(1'b0, 32'h0);
        wait_done();
        checks++;
        if (q_data.size() != 16) begin
            errors++;
            $display("FAIL neg_count: got %0d results required 16", q_data.size());
        end
        for (int i = 0; i < q_data.size() && i < 16; i++) begin
            checks++;
            if (q_data[i] != exp_v) begin
                errors++;
                $display("FAIL neg_result[%0d]: data=%0d required %0d", i, q_data[i], exp_v);
            end
        end
        mode = 1'b0;
    endtask

    task automatic test_backpressure();
        int n = 0;
        mode = 1'b0;
        res.ready = 1'b1;
        load_w(32'h0000_0001);
        start_run(1'b0, 32'h0);
        while (!(res.valid && res.idx == 4'd3) && n < 40) begin
            tick();
            n++;
        end
        checks++;
        if (n >= 40) begin
            errors++;
            $display("FAIL stall_find_idx3: idx 3 never presented within 40 cycles");
        end
        res.ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            checks++;
            if (res.valid !== 1'b1 || res.data !== 18'sd3 || res.idx !== 4'd3) begin
                errors++;
                $display("FAIL stall_hold[%0d]: valid=%0b data=%0d idx=%0d required 1/3/3",
                         c, res.valid, res.data, res.idx);
            end
            checks++;
            if (rd_addr !== 6'd5) begin
                errors++;
                $display("FAIL stall_addr[%0d]: rd_addr=%0d required 5", c, rd_addr);
            end
        end
        res.ready = 1'b1;
        wait_done();
        checks++;
        if (q_data.size() != 16) begin
            errors++;
            $display("FAIL stall_count: got %0d results required 16", q_data.size());
        end
        for (int i = 0; i < q_data.size() && i < 16; i++) begin
            checks++;
            if (q_idx[i] != i || q_data[i] != i) begin
                errors++;
                $display("FAIL stall_result[%0d]: idx=%0d data=%0d required %0d/%0d",
                         i, q_idx[i], q_data[i], i, i);
            end
        end
    endtask

    task automatic test_reset_mid_run();
        int n = 0;
        int held;
        res.ready = 1'b1;
        load_w(32'h0101_0101);
        start_run(1'b0, 32'h0);
        while (!(res.valid && res.idx == 4'd7) && n < 40) begin
            tick();
            n++;
        end
        checks++;
        if (n >= 40) begin
            errors++;
            $display("FAIL rstmid_find_idx7: idx 7 never presented within 40 cycles");
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({rd_addr, busy, done, res.valid, res.idx} !== 13'd0 || res.data !== 18'sd0) begin
            errors++;
            $display("FAIL rstmid_outputs: addr=%0d busy=%0b valid=%0b idx=%0d data=%0d required all 0",
                     rd_addr, busy, res.valid, res.idx, res.data);
        end
        held = q_data.size();
        tick();
        tick();
        rst = 1'b0;
        for (int c = 0; c < 6; c++) tick();
        checks++;
        if (done_cnt != 0 || q_data.size() != held || busy !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_quiet: done=%0d extra=%0d busy=%0b required 0/0/0",
                     done_cnt, q_data.size() - held, busy);
        end
        // the kernel was cleared by reset, so the fresh sweep yields zeros
        start_run(1'b0, 32'h0);
        wait_done();
        checks++;
        if (q_data.size() != 16 || done_cnt != 1) begin
            errors++;
            $display("FAIL rstmid_rerun: results=%0d done=%0d required 16/1", q_data.size(), done_cnt);
        end
        for (int i = 0; i < q_data.size() && i < 16; i++) begin
            checks++;
            if (q_idx[i] != i || q_data[i] != 0) begin
                errors++;
                $display("FAIL rstmid_result[%0d]: idx=%0d data=%0d required %0d/0", i, q_idx[i], q_data[i], i);
            end
        end
    endtask

    task automatic test_ignore_mid_run();
        res.ready = 1'b1;
        load_w(32'h0101_0101);
        start_run(1'b0, 32'h0);
        for (int c = 0; c < 5; c++) tick();
        start = 1'b1;
        w_load = 1'b1;
        w_data = 32'h0202_0202;
        tick();
        start = 1'b0;
        w_load = 1'b0;
        wait_done();
        for (int c = 0; c < 4; c++) tick();
        checks++;
        if (q_data.size() != 16 || done_cnt != 1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL ignore_run: results=%0d done=%0d busy=%0b required 16/1/0",
                     q_data.size(), done_cnt, busy);
        end
        for (int i = 0; i < q_data.size() && i < 16; i++) begin
            checks++;
            if (q_data[i] != 4 * i) begin
                errors++;
                $display("FAIL ignore_result[%0d]: data=%0d required %0d", i, q_data[i], 4 * i);
            end
        end
        start_run(1'b0, 32'h0);
        wait_done();
        checks++;
        if (q_data.size() != 16 || q_data[5] != 20 || q_data[15] != 60) begin
            errors++;
            $display("FAIL ignore_next_run: n=%0d required 16 results with old kernel (idx5=20, idx15=60)",
                     q_data.size());
        end
        // new kernel loaded in the same cycle as start applies to that run
        start_run(1'b1, 32'h0202_0202);
        wait_done();
        checks++;
        if (q_data.size() != 16) begin
            errors++;
            $display("FAIL newk_count: got %0d results required 16", q_data.size());
        end
        for (int i = 0; i < q_data.size() && i < 16; i++) begin
            checks++;
            if (q_data[i] != 8 * i) begin
                errors++;
                $display("FAIL newk_result[%0d]: data=%0d required %0d", i, q_data[i], 8 * i);
            end
        end
    endtask

    initial begin
        start = 1'b0;
        w_load = 1'b0;
        w_data = 32'h0;
        mode = 1'b0;
        res.ready = 1'b1;
        test_reset();
        test_sweep();
        test_negative();
        test_backpressure();
        test_reset_mid_run();
        test_ignore_mid_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
